// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller and its bench:
//   - DEFAULT_WIDTH : default operand/result width in bits
//   - state_t       : controller state encoding (S_IDLE, S_SHIFT, S_DONE)
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit
// Purely combinational single-bit full adder cell.
// Ports:
//   i_a, i_b : operand bits
//   i_ci     : carry in
//   o_s      : sum bit
//   o_co     : carry out
module full_adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Sequences a single full_adder_bit over WIDTH clock cycles, LSB first, to
// add (a + b + cin) or subtract (a - b) two WIDTH-bit operands.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_start  : request, accepted in IDLE or DONE only
//   i_sub    : 0 = add with carry-in, 1 = subtract (carry-in ignored)
//   i_a, i_b : operands, captured with i_start
//   i_cin    : carry-in for addition, captured with i_start
//   o_busy   : high while bits are being shifted through the adder
//   o_done   : one-cycle pulse, result valid
//   o_sum    : result shift register (partial while o_busy is high)
//   o_cout   : final carry-out (1 = no borrow when subtracting)
//   o_ovf    : signed overflow of the final result
module serial_add_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_areg;
    logic [WIDTH-1:0] r_breg;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_s;
    logic             w_co;

    full_adder_bit u_fa (
        .i_a  (r_areg[0]),
        .i_b  (r_breg[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // Next-state and datapath control decode.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Requests arriving here are dropped on purpose.
                w_step = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_areg  <= '0;
            r_breg  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            r_areg  <= i_a;
            r_breg  <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_carry <= w_co;
            r_areg  <= r_areg >> 1;
            r_breg  <= r_breg >> 1;
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            if (w_last) begin
                r_cout <= w_co;
                // r_carry here is the carry into the MSB.
                r_ovf  <= r_carry ^ w_co;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // Outputs are decoded from registers only; nothing from inputs reaches them.
    assign o_busy = (r_state == S_SHIFT);
    assign o_done = (r_state == S_DONE);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic fa_a, fa_b, fa_ci, fa_s, fa_co;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_sub   (sub),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_ovf   (ovf)
    );

    full_adder_bit u_ref_fa (
        .i_a  (fa_a),
        .i_b  (fa_b),
        .i_ci (fa_ci),
        .o_s  (fa_s),
        .o_co (fa_co)
    );

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        int ua, ub, sa, sb, ures, sres;
        logic [W-1:0] s;
        logic co, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            ures = ua - ub;
            sres = sa - sb;
            co   = (ua >= ub);
        end else begin
            ures = ua + ub + int'(mc);
            sres = sa + sb + int'(mc);
            co   = (ures > 255);
        end
        s  = ures[W-1:0];
        ov = (sres > 127) || (sres < -128);
        return {ov, co, s};
    endfunction

    // Issue one request from a point between edges and follow it until done.
    // lat counts rising edges after the accepting edge until done is seen.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic oc, input logic os,
                         output int lat, output int busy_cnt, output int both_cnt);
        a = oa; b = ob; cin = oc; sub = os; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = -1; busy_cnt = 0; both_cnt = 0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && done) both_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_full_adder_cell;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] expv;
            v = 3'(i);
            fa_a = v[2]; fa_b = v[1]; fa_ci = v[0];
            expv = 2'(int'(v[2]) + int'(v[1]) + int'(v[0]));
            #1;
            checks++;
            if ({fa_co, fa_s} !== expv) begin
                errors++;
                $display("FAIL fa_cell in=%b got co,s=%b want %b", v, {fa_co, fa_s}, expv);
            end
        end
    endtask

    task automatic run_and_check(input string nm, input logic [W-1:0] oa, input logic [W-1:0] ob,
                                 input logic oc, input logic os);
        int lat, bc, both;
        logic [W+1:0] expv;
        expv = model(oa, ob, oc, os);
        do_op(oa, ob, oc, os, lat, bc, both);
        checks++;
        if (lat !== W || bc !== W || both !== 0) begin
            errors++;
            $display("FAIL %s_timing a=%h b=%h got lat=%0d busy=%0d overlap=%0d want %0d %0d 0",
                     nm, oa, ob, lat, bc, both, W, W);
        end
        checks++;
        if ({ovf, cout, sum} !== expv) begin
            errors++;
            $display("FAIL %s_result a=%h b=%h cin=%b sub=%b got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     nm, oa, ob, oc, os, ovf, cout, sum, expv[W+1], expv[W], expv[W-1:0]);
        end
        $display("op %s a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                 nm, oa, ob, oc, os, sum, cout, ovf, lat);
        @(negedge clk);
    endtask

    task automatic test_directed;
        run_and_check("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0);
        checks++;
        if ({ovf, cout, sum} !== {1'b1, 1'b0, 8'h8D}) begin
            errors++;
            $display("FAIL plan_5a_33 got %b%b %h want ovf=1 cout=0 sum=8d", ovf, cout, sum);
        end
        run_and_check("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_and_check("add_cin",   8'h00, 8'h00, 1'b1, 1'b0);
        run_and_check("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1);
        run_and_check("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1);
        checks++;
        if ({ovf, cout, sum} !== {1'b1, 1'b1, 8'h7F}) begin
            errors++;
            $display("FAIL plan_80_01 got %b%b %h want ovf=1 cout=1 sum=7f", ovf, cout, sum);
        end
    endtask

    task automatic test_start_during_shift;
        int first, ndone;
        logic [W+1:0] expv, got;
        expv = model(8'h3C, 8'h47, 1'b1, 1'b0);
        a = 8'h3C; b = 8'h47; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = -1; ndone = 0; got = '0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                a = 8'hC1; b = 8'h7E; cin = 1'b0; sub = 1'b1; start = 1'b1;
            end else if (k == 4) begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    got = {ovf, cout, sum};
                end
            end
        end
        checks++;
        if (ndone !== 1 || first !== W) begin
            errors++;
            $display("FAIL ignore_start_timing got dones=%0d first=%0d want 1 %0d", ndone, first, W);
        end
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL ignore_start_result got %b want %b", got, expv);
        end
        $display("op ignore_start dones=%0d first=%0d result=%b", ndone, first, got);
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, bc, both, c1, c2;
        logic [W+1:0] e1, e2;
        e1 = model(8'h64, 8'h9B, 1'b0, 1'b0);
        e2 = model(8'hFF, 8'h81, 1'b0, 1'b0);
        do_op(8'h64, 8'h9B, 1'b0, 1'b0, lat1, bc, both);
        c1 = cyc;
        checks++;
        if (lat1 !== W || {ovf, cout, sum} !== e1) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d res=%b want %0d %b", lat1, {ovf, cout, sum}, W, e1);
        end
        // Still inside the done cycle: the next request is accepted on the coming edge.
        do_op(8'hFF, 8'h81, 1'b0, 1'b0, lat2, bc, both);
        c2 = cyc;
        checks++;
        if (lat2 !== W || bc !== W || both !== 0 || (c2 - c1) !== W + 1) begin
            errors++;
            $display("FAIL b2b_timing got lat=%0d busy=%0d overlap=%0d gap=%0d want %0d %0d 0 %0d",
                     lat2, bc, both, c2 - c1, W, W, W + 1);
        end
        checks++;
        if ({ovf, cout, sum} !== e2) begin
            errors++;
            $display("FAIL b2b_second got %b want %b", {ovf, cout, sum}, e2);
        end
        $display("op back_to_back gap=%0d sum1=%h sum2=%h", c2 - c1, e1[W-1:0], sum);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift;
        int ndone;
        a = 8'hA7; b = 8'h5E; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before_reset got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done got active_cycles=%0d want 0", ndone);
        end
        $display("op reset_mid_shift activity_after=%0d", ndone);
        run_and_check("after_reset", 8'hA7, 8'h5E, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom);
            rs = 1'($urandom);
            run_and_check("rand", ra, rb, rc, rs);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        fa_a = 1'b0; fa_b = 1'b0; fa_ci = 1'b0;
        test_reset();
        test_full_adder_cell();
        test_directed();
        test_start_during_shift();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencing controller for the bit-serial adder datapath. It accepts a start request with two WIDTH-bit operands and loads them into internal shift registers. It then drives a 1-bit full adder LSB-first for exactly WIDTH clock cycles, holding the carry in a flip-flop, and returns the registered sum, carry-out and signed-overflow with a one-cycle `done` pulse. It sits between the system that issues add/subtract requests and the single-bit adder cell, and sequences all use of that cell.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH ≥ 2.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE or DONE.
- `sub`  in  1: operation select; 0 = a+b+cin, 1 = a−b (two's complement, cin ignored); sampled with `start`.
- `a`  in  WIDTH: operand A; sampled with `start`.
- `b`  in  WIDTH: operand B; sampled with `start`.
- `cin`  in  1: carry-in for addition; sampled with `start`.
- `busy`  out  1: high while in SHIFT.
- `done`  out  1: one-cycle pulse; result valid.
- `sum`  out  WIDTH: result; holds its value until the next accepted start.
- `cout`  out  1: final carry-out. For subtraction, 1 means no borrow.
- `ovf`  out  1: signed overflow = (carry into MSB) XOR (carry out of MSB).

## Operation
- States:
  - IDLE: `start`=1 → load, then go to SHIFT.
  - SHIFT: advance one bit per cycle; after bit WIDTH−1 → DONE.
  - DONE: `start`=1 → load, then go to SHIFT (back-to-back); otherwise → IDLE.
- Load action (single edge):
  - areg ← a.
  - breg ← sub ? ~b : b.
  - carry ← sub ? 1 : cin.
  - bit counter ← 0.
- Each SHIFT cycle:
  - The full adder computes s = areg[0] ^ breg[0] ^ carry.
  - carry ← its carry-out.
  - areg and breg shift right by one.
  - s shifts into the MSB of the sum register (the sum register shifts right).
  - counter increments.
- At counter = WIDTH−1, the same edge performs the following:
  - cout ← final carry.
  - ovf ← carry-in of this bit XOR final carry.
  - state ← DONE.
- `start` while in SHIFT is ignored. The operation is not restarted or queued, and there is no error indication.
- The counter is $clog2(WIDTH) bits wide. Its terminal compare is against the constant WIDTH−1, so it never wraps in use.
- `sum` is the internal shift register. It shows partial bits while `busy`=1, and consumers must read it only when `done`=1 or later.
- `cout` and `ovf` update only on the final SHIFT edge. They hold their values through DONE and IDLE.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system) forces:
  - state IDLE;
  - `busy`=0, `done`=0;
  - `sum`=0, `cout`=0, `ovf`=0;
  - internal carry and counter = 0.
- Reset asserted mid-SHIFT aborts the operation immediately. No `done` pulse is produced.
- Latency:
  - The sampling edge of `start` is edge 0.
  - `busy`=1 from edge 0 to edge WIDTH.
  - `done`=1 from edge WIDTH to edge WIDTH+1.
  - Total: WIDTH+1 cycles per operation.
- Back-to-back: `start`=1 during the `done` cycle produces `busy`=1 on the next cycle. There is no idle gap, so throughput is one result per WIDTH+1 cycles.
- `busy` and `done` are never high in the same cycle. All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `serial_adder_pkg` holds:
  - the state encoding constants S_IDLE, S_SHIFT, S_DONE (2 bits);
  - the default WIDTH constant.
- One sub-module, `full_adder_bit`: purely combinational, with inputs a, b, ci and outputs s, co. It is instantiated once and reused by the testbench for reference checks.
- The controller FSM, counter, shift registers and carry flip-flop all live in `serial_add_ctrl`.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0, sub=0 → after 9 cycles `done`=1, `sum`=0x8D, `cout`=0, `ovf`=1.
- a=0xFF, b=0x01, cin=0, sub=0 → `sum`=0x00, `cout`=1, `ovf`=0. Also a=0x00, b=0x00, cin=1 → `sum`=0x01, `cout`=0.
- sub=1, a=0x10, b=0x20 → `sum`=0xF0, `cout`=0, `ovf`=0. Also sub=1, a=0x80, b=0x01 → `sum`=0x7F, `cout`=1, `ovf`=1.
- Pulse `start` at shift cycle 3 with different operands → ignored; the original result and timing are unchanged and there is exactly one `done` pulse.
- Hold `start`=1 through the `done` cycle with new operands → `busy` rises on the next cycle, and a second `done` follows 9 cycles after the first with the correct second sum.
- Assert `rst_n`=0 at shift cycle 4 → all outputs read 0 within the same cycle, there is no `done` pulse, and a subsequent start computes correctly.
